vram_port_arbiter: RTL and testbench
====================================

# vram_port_arbiter

Shares one single-port synchronous text/video RAM between the VGA display pixel pipeline and a background writer, such as a switch/update sequencer. Sits between the sync/data-generator pair and the RAM. The display read path has absolute priority and never stalls. The writer uses a req/ack handshake and can be restricted to blanking intervals. Every memory-side output is registered, so the RAM sees clean, glitch-free controls.

## Interface
- AW, 12, RAM address width (80x30 character cells)
- DW, 8, RAM data width
- WR_BLANK_ONLY, 1, 1 = writer is granted only while video_on = 0
- MAX_WAIT, 1023, consecutive denied-writer cycles before starvation flag sets
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- video_on  in  1  from sync generator; high in visible area
- disp_req  in  1  one-cycle display read request
- disp_addr  in  AW  display read address, valid with disp_req
- disp_data  out  DW  display read data
- disp_valid  out  1  one-cycle strobe qualifying disp_data
- wr_req  in  1  writer request; held until wr_ack
- wr_addr  in  AW  writer address; stable while wr_req is high
- wr_data  in  DW  writer data; stable while wr_req is high
- wr_ack  out  1  one-cycle grant/commit pulse
- wr_starve  out  1  sticky flag: writer denied for MAX_WAIT consecutive cycles
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data; 1-cycle latency after mem_en

## Operation
- Slot register `slot` ∈ {IDLE, DISP, WR} selects the memory operation for the next cycle. A new decision is made every clk.
- Decision in cycle N, in priority order:
  - disp_req = 1 → DISP.
  - Otherwise, if wr_req = 1, wr_ack = 0 in cycle N, and (WR_BLANK_ONLY = 0 or video_on = 0) → WR.
  - Otherwise → IDLE.
- DISP slot (cycle N+1): mem_en = 1, mem_we = 0, mem_addr = disp_addr captured at N.
- WR slot (cycle N+1): mem_en = 1, mem_we = 1, mem_addr/mem_wdata = wr_addr/wr_data captured at N. wr_ack = 1 in the same cycle.
- IDLE slot: mem_en = 0, mem_we = 0. mem_addr and mem_wdata hold their previous values.
- Grant blocking while wr_ack is high means the writer's stale request cannot be double-granted. Maximum write rate is therefore one per two cycles.
- Display reads are never dropped or delayed. A disp_req on every cycle is legal and starves the writer.
- Wait counter, width ceil(log2(MAX_WAIT+1)):
  - Increments in each cycle where wr_req = 1 and the writer is not granted.
  - Clears on a grant or when wr_req = 0.
  - Saturates at MAX_WAIT.
  - Reaching MAX_WAIT sets wr_starve, which stays set until reset.
- A wr_req that drops without wr_ack is a protocol violation. The arbiter just stops considering it, and any pending grant decision for that request is not cancelled.

## Timing
- Display read latency: disp_req at cycle N → mem_en at N+1 → mem_rdata at N+2 → disp_data registered and disp_valid = 1 at N+3. A back-to-back disp_req stream produces back-to-back disp_valid.
- Writer latency: wr_req first eligible at N → wr_ack and the RAM write at N+1.
- video_on is sampled in the decision cycle. A WR decision made in the last blanking cycle still completes in cycle N+1, even if video is then on.
- Reset (asynchronous assert) takes effect immediately:
  - slot = IDLE; mem_en = mem_we = 0; mem_addr = mem_wdata = 0.
  - disp_valid = 0; disp_data = 0; wr_ack = 0; wr_starve = 0; wait counter = 0.
- Reset during an in-flight read: the read is discarded and no disp_valid is produced for it.
- Reset during a write: a write already driven to the RAM is not undone. A write that was decided but not yet driven never occurs and is not acked.
- Reset is released synchronously to clk by the top level. The first decision is made in the first cycle after release.

## Structure
- Shared package `vga_pkg` holds:
  - slot encoding: IDLE = 2'd0, DISP = 2'd1, WR = 2'd2
  - default AW/DW
  - character grid constants: 80 columns, 30 rows
- One natural sub-module: `disp_read_pipe`, a 2-stage valid/data shift for the display return path. Everything else is a flat FSM plus counter.

## Test plan
- Single write in blanking: video_on = 0, wr_req with addr 0x123, data 0x5A at cycle 0 → wr_ack, mem_we = 1 and mem_addr = 0x123 at cycle 1. A later read of 0x123 returns 0x5A with disp_valid at request + 3.
- Collision: disp_req (addr 0x010) and wr_req (addr 0x020) both at cycle 0 → DISP at cycle 1, WR at cycle 2, wr_ack at cycle 2.
- Back-to-back writer requests: wr_req held with new addr/data each cycle after ack → writes occur at most every other cycle, with no duplicate write of the same address/data.
- WR_BLANK_ONLY = 1: wr_req held with video_on = 1 for 50 cycles → no wr_ack. Drop video_on at cycle 50 → wr_ack at cycle 51.
- Starvation: MAX_WAIT = 8, disp_req every cycle, wr_req held → wr_starve rises after 8 denied cycles. It stays high after disp_req stops and the write is acked.
- Reset mid-read: disp_req at cycle 0, reset asserted at cycle 2 → no disp_valid at cycle 3, and all outputs are 0 while reset is high.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and slot encoding for the VGA text/video RAM path.
// Imported by the arbiter and its display return pipe.
package vga_pkg;

   localparam int AW_DEF = 12;
   localparam int DW_DEF = 8;

   localparam int TXT_COLS = 80;
   localparam int TXT_ROWS = 30;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DISP = 2'd1,
      WR   = 2'd2
   } slot_t;

endpackage

// File: rtl/vram_port_arbiter_disp_read_pipe.sv
// Display return path: tracks an issued RAM read through the
// one-cycle RAM latency and registers the returned data.
module disp_read_pipe #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rd_issue,
   input  logic [DW-1:0] rdata,
   output logic [DW-1:0] data,
   output logic          valid
);

   logic rd_pend;

   // Stage 1 marks RAM data arriving; stage 2 captures it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend <= 1'b0;
         valid   <= 1'b0;
         data    <= '0;
      end else begin
         rd_pend <= rd_issue;
         valid   <= rd_pend;
         if (rd_pend)
            data <= rdata;
      end
   end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads always win, the writer
// gets leftover (optionally blanking-only) slots via req/ack.
module vram_port_arbiter
   import vga_pkg::*;
#(
   parameter int   AW            = AW_DEF,
   parameter int   DW            = DW_DEF,
   parameter logic WR_BLANK_ONLY = 1'b1,
   parameter int   MAX_WAIT      = 1023
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          video_on,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic [DW-1:0] disp_data,
   output logic          disp_valid,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   output logic          wr_starve,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   slot_t         slot;
   slot_t         slot_d;
   logic          wr_ok;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_d;

   // Writer eligibility; the ack cycle blocks a stale re-grant.
   always_comb begin
      wr_ok = wr_req && !wr_ack
              && (!WR_BLANK_ONLY || !video_on);
   end

   // Next-slot decision: display first, then writer, else idle.
   always_comb begin
      slot_d = IDLE;
      if (disp_req)
         slot_d = DISP;
      else if (wr_ok)
         slot_d = WR;
      else
         slot_d = IDLE;
   end

   // Slot register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         slot <= IDLE;
      else
         slot <= slot_d;
   end

   // Registered RAM controls and write ack for the decided slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wr_ack    <= 1'b0;
      end else begin
         mem_en <= (slot_d != IDLE);
         mem_we <= (slot_d == WR);
         wr_ack <= (slot_d == WR);
         case (slot_d)
            DISP: mem_addr <= disp_addr;
            WR: begin
               mem_addr  <= wr_addr;
               mem_wdata <= wr_data;
            end
            default: ;
         endcase
      end
   end

   // Consecutive-denial count; cleared by grant, ack or idle writer.
   always_comb begin
      wait_d = wait_cnt;
      if (!wr_req || wr_ack || slot_d == WR)
         wait_d = '0;
      else if (wait_cnt != WAIT_MAX)
         wait_d = wait_cnt + 1'b1;
   end

   // Wait counter and sticky starvation flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         wr_starve <= 1'b0;
      end else begin
         wait_cnt <= wait_d;
         if (wait_d == WAIT_MAX)
            wr_starve <= 1'b1;
      end
   end

   disp_read_pipe #(
      .DW (DW)
   ) u_rd_pipe (
      .clk      (clk),
      .reset    (reset),
      .rd_issue (slot == DISP),
      .rdata    (mem_rdata),
      .data     (disp_data),
      .valid    (disp_valid)
   );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomized and directed bench for vram_port_arbiter with a
// transaction-level reference model and a behavioural RAM.
module tb_vram_port_arbiter;

   localparam int AW   = 12;
   localparam int DW   = 8;
   localparam int MAXW = 8;
   localparam logic BLANK = 1'b1;

   logic          clk = 1'b0;
   logic          reset;
   logic          video_on;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          wr_starve;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vram_port_arbiter #(
      .AW            (AW),
      .DW            (DW),
      .WR_BLANK_ONLY (BLANK),
      .MAX_WAIT      (MAXW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .video_on   (video_on),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .wr_starve  (wr_starve),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Behavioural synchronous single-port RAM, 1-cycle read latency.
   logic [DW-1:0] ram [4096];
   initial mem_rdata = '0;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   // Reference model state.
   logic [DW-1:0] shadow [4096];
   logic          m_en, m_we, m_ack, m_starve;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   int            m_wait;
   int            cyc = 0;
   int            due_q[$];
   logic [DW-1:0] dat_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_we = 0; m_ack = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_wait = 0;
      due_q.delete();
      dat_q.delete();
   endtask

   // Apply the arbitration rules to the inputs seen at this edge.
   task automatic model_edge();
      logic g;
      cyc++;
      g = !disp_req && wr_req && !m_ack && (!BLANK || !video_on);
      if (!wr_req || g || m_ack) m_wait = 0;
      else if (m_wait < MAXW)    m_wait++;
      if (m_wait == MAXW) m_starve = 1;
      if (disp_req) begin
         m_en = 1; m_we = 0; m_addr = disp_addr;
         due_q.push_back(cyc + 2);
         dat_q.push_back(shadow[disp_addr]);
      end else if (g) begin
         m_en = 1; m_we = 1; m_addr = wr_addr; m_wdata = wr_data;
         shadow[wr_addr] = wr_data;
      end else begin
         m_en = 0; m_we = 0;
      end
      m_ack = g;
   endtask

   task automatic compare();
      logic ev;
      logic [DW-1:0] ed;
      ev = 0;
      ed = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         ev = 1;
         ed = dat_q[0];
         void'(due_q.pop_front());
         void'(dat_q.pop_front());
      end
      chk("mem_en", 32'(mem_en), 32'(m_en));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("wr_ack", 32'(wr_ack), 32'(m_ack));
      chk("wr_starve", 32'(wr_starve), 32'(m_starve));
      chk("disp_valid", 32'(disp_valid), 32'(ev));
      if (ev) chk("disp_data", 32'(disp_data), 32'(ed));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic idle_in();
      disp_req = 0;
      wr_req = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_en"}, 32'(mem_en), 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_ack"}, 32'(wr_ack), 0);
      chk({tag, "_starve"}, 32'(wr_starve), 0);
      chk({tag, "_valid"}, 32'(disp_valid), 0);
      chk({tag, "_data"}, 32'(disp_data), 0);
   endtask

   task automatic do_reset();
      reset = 1;
      model_reset();
      @(posedge clk);
      cyc++;
      #1;
      chk_zero("rst");
      reset = 0;
   endtask

   int acks;
   int pend_n;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i] = '0;
         shadow[i] = '0;
      end
      video_on = 0; disp_addr = '0; wr_addr = '0; wr_data = '0;
      idle_in();
      reset = 1;
      model_reset();
      #2;
      chk_zero("por");
      @(posedge clk);
      #1;
      reset = 0;

      // Single write in blanking, then read it back.
      wr_req = 1; wr_addr = 12'h123; wr_data = 8'h5A;
      step();
      chk("w1_ack", 32'(wr_ack), 1);
      chk("w1_we", 32'(mem_we), 1);
      chk("w1_addr", 32'(mem_addr), 32'h123);
      wr_req = 0;
      step();
      disp_req = 1; disp_addr = 12'h123;
      step();
      disp_req = 0;
      step();
      step();
      chk("rb_valid", 32'(disp_valid), 1);
      chk("rb_data", 32'(disp_data), 32'h5A);

      // Collision: display wins, writer follows one cycle later.
      disp_req = 1; disp_addr = 12'h010;
      wr_req = 1; wr_addr = 12'h020; wr_data = 8'h33;
      step();
      chk("col_rd_we", 32'(mem_we), 0);
      chk("col_rd_addr", 32'(mem_addr), 32'h010);
      chk("col_rd_ack", 32'(wr_ack), 0);
      disp_req = 0;
      step();
      chk("col_wr_ack", 32'(wr_ack), 1);
      chk("col_wr_addr", 32'(mem_addr), 32'h020);
      wr_req = 0;
      step();

      // Back-to-back writer: new request presented on each ack.
      acks = 0;
      wr_req = 1; wr_addr = 12'h040; wr_data = 8'h01;
      for (int i = 0; i < 20; i++) begin
         step();
         if (m_ack) begin
            acks++;
            wr_addr = wr_addr + 1'b1;
            wr_data = wr_data + 1'b1;
         end
      end
      chk("b2b_acks", 32'(acks), 10);
      wr_req = 0;
      step();

      // Blanking-only: no grant during video, grant right after.
      video_on = 1;
      wr_req = 1; wr_addr = 12'h077; wr_data = 8'hC3;
      acks = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (wr_ack) acks++;
      end
      chk("blank_noack", 32'(acks), 0);
      video_on = 0;
      step();
      chk("blank_ack", 32'(wr_ack), 1);
      chk("blank_addr", 32'(mem_addr), 32'h077);
      wr_req = 0;
      step();

      // Reset in the middle of a display read.
      disp_req = 1; disp_addr = 12'h077;
      step();
      disp_req = 0;
      step();
      #1;
      reset = 1;
      model_reset();
      #1;
      chk_zero("mid");
      @(posedge clk);
      cyc++;
      #1;
      chk_zero("mid2");
      reset = 0;
      step();
      step();

      // Starvation under continuous display reads.
      disp_req = 1; disp_addr = 12'h001;
      wr_req = 1; wr_addr = 12'h0AA; wr_data = 8'h99;
      for (int i = 0; i < 7; i++) step();
      chk("starve_pre", 32'(wr_starve), 0);
      step();
      chk("starve_set", 32'(wr_starve), 1);
      step();
      step();
      disp_req = 0;
      step();
      chk("starve_ack", 32'(wr_ack), 1);
      chk("starve_hold", 32'(wr_starve), 1);
      wr_req = 0;
      step();
      step();
      chk("starve_stick", 32'(wr_starve), 1);

      // Randomized traffic over a small address window.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step();
         disp_req = ($urandom_range(0, 2) == 0);
         disp_addr = 12'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) video_on = ~video_on;
         if (wr_req) begin
            if (m_ack) begin
               if ($urandom_range(0, 1) == 0) begin
                  wr_addr = 12'($urandom_range(0, 15));
                  wr_data = 8'($urandom);
               end else begin
                  wr_req = 0;
               end
            end
         end else if ($urandom_range(0, 3) == 0) begin
            wr_req = 1;
            wr_addr = 12'($urandom_range(0, 15));
            wr_data = 8'($urandom);
         end
      end
      idle_in();
      for (int i = 0; i < 4; i++) step();
      pend_n = due_q.size();
      chk("rand_drain", 32'(pend_n), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
